// File: rtl/pll_rst_ctrl.sv
// PLL bring-up sequencer: holds the PLL in reset, waits for a stable lock with
// bounded retries, then releases the user reset; a software request restarts it.
module pll_rst_ctrl #(
  parameter int RST_CYCLES   = 100,
  parameter int LOCK_TIMEOUT = 50000,
  parameter int LOCK_STABLE  = 1024,
  parameter int MAX_RETRY    = 7
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic       pll_lock,
  input  logic       sw_rst_req,
  output logic       pll_rst,
  output logic       user_rst_n,
  output logic       ready,
  output logic       fail,
  output logic [2:0] retry_cnt
);

  localparam int MAX_AB  = (RST_CYCLES > LOCK_TIMEOUT) ? RST_CYCLES : LOCK_TIMEOUT;
  localparam int MAX_ALL = (MAX_AB > LOCK_STABLE) ? MAX_AB : LOCK_STABLE;
  localparam int CW      = $clog2(MAX_ALL) + 1;

  localparam logic [CW-1:0] RST_LAST     = CW'(RST_CYCLES - 1);
  localparam logic [CW-1:0] TIMEOUT_LAST = CW'(LOCK_TIMEOUT - 1);
  localparam logic [CW-1:0] STABLE_LAST  = CW'(LOCK_STABLE - 1);
  localparam logic [2:0]    RETRY_MAX    = 3'(MAX_RETRY);

  typedef enum logic [2:0] {
    S_RESET,
    S_WAIT_LOCK,
    S_STABLE,
    S_RUN,
    S_FAIL
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    retry_d;
  logic          lock_meta, lock_s;
  logic          restart;

  // Two-flop synchronizer; lock_s is the only view of pll_lock inside the block.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values, which is what makes the two stages a real delay line.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      lock_meta <= 1'b0;
      lock_s    <= 1'b0;
    end else begin
      lock_meta <= pll_lock;
      lock_s    <= lock_meta;
    end
  end

  // NOTE: every variable gets a default before the case so no path leaves one
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    retry_d = retry_cnt;
    restart = 1'b0;
    if (sw_rst_req) begin
      state_d = S_RESET;
      retry_d = '0;
      restart = 1'b1;
    end else begin
      case (state_q)
        S_RESET: begin
          if (cnt_q == RST_LAST) state_d = S_WAIT_LOCK;
        end
        S_WAIT_LOCK: begin
          if (lock_s) begin
            state_d = S_STABLE;
          end else if (cnt_q == TIMEOUT_LAST) begin
            if (retry_cnt == RETRY_MAX) begin
              state_d = S_FAIL;
            end else begin
              state_d = S_RESET;
              retry_d = retry_cnt + 3'd1;
            end
          end
        end
        S_STABLE: begin
          if (!lock_s)                    state_d = S_WAIT_LOCK;
          else if (cnt_q == STABLE_LAST)  state_d = S_RUN;
        end
        S_RUN: begin
          if (!lock_s) state_d = S_RESET;
        end
        S_FAIL: begin
          state_d = S_FAIL;
        end
        default: state_d = S_RESET;
      endcase
    end

    if (state_d == S_RUN && state_q != S_RUN) retry_d = '0;

    // RUN and FAIL never look at the counter, so it is parked at zero there.
    if (restart || state_d != state_q || state_d == S_RUN || state_d == S_FAIL)
      cnt_d = '0;
    else
      cnt_d = cnt_q + 1'b1;
  end

  // Outputs are decoded from the next state so they flip on the same edge as state.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q    <= S_RESET;
      cnt_q      <= '0;
      retry_cnt  <= '0;
      pll_rst    <= 1'b1;
      user_rst_n <= 1'b0;
      ready      <= 1'b0;
      fail       <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      retry_cnt  <= retry_d;
      pll_rst    <= (state_d == S_RESET) || (state_d == S_FAIL);
      user_rst_n <= (state_d == S_RUN);
      ready      <= (state_d == S_RUN);
      fail       <= (state_d == S_FAIL);
    end
  end

endmodule

// File: tb/tb_pll_rst_ctrl.sv
// Self-checking bench for pll_rst_ctrl: directed bring-up scenarios followed by
// randomized lock/software-reset traffic, compared each cycle to a phase/dwell model.
module tb_pll_rst_ctrl;

  localparam int RST_CYCLES   = 4;
  localparam int LOCK_TIMEOUT = 16;
  localparam int LOCK_STABLE  = 8;
  localparam int MAX_RETRY    = 2;

  logic       sys_clk = 1'b0;
  logic       sys_rst_n;
  logic       pll_lock;
  logic       sw_rst_req;
  logic       pll_rst;
  logic       user_rst_n;
  logic       ready;
  logic       fail;
  logic [2:0] retry_cnt;

  always #5 sys_clk = ~sys_clk;

  pll_rst_ctrl #(
    .RST_CYCLES  (RST_CYCLES),
    .LOCK_TIMEOUT(LOCK_TIMEOUT),
    .LOCK_STABLE (LOCK_STABLE),
    .MAX_RETRY   (MAX_RETRY)
  ) dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .pll_lock  (pll_lock),
    .sw_rst_req(sw_rst_req),
    .pll_rst   (pll_rst),
    .user_rst_n(user_rst_n),
    .ready     (ready),
    .fail      (fail),
    .retry_cnt (retry_cnt)
  );

  // Reference model: which phase we are in, the edge it was entered on, and
  // the history of pll_lock values seen at each edge.
  typedef enum {M_RESET, M_WAIT, M_STABLE, M_RUN, M_FAIL} mphase_t;

  mphase_t m_phase;
  int      m_entry;
  int      m_k;
  int      m_retry;
  logic    hist[$];

  int n_checks = 0;
  int n_fails  = 0;

  task automatic check_bit(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %b expected %b (edge %0d)", tag, obs, exp, m_k);
    end
  endtask

  task automatic check_int(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %0d expected %0d (edge %0d)", tag, obs, exp, m_k);
    end
  endtask

  task automatic model_reset();
    m_phase = M_RESET;
    m_entry = 0;
    m_k     = 0;
    m_retry = 0;
    hist    = '{1'b0, 1'b0};
  endtask

  // The FSM sees pll_lock as it was two edges earlier; each phase lasts a
  // fixed number of edges unless a lock event or request cuts it short.
  task automatic model_edge(input logic lk, input logic sw);
    logic    ls;
    int      dwell;
    mphase_t nxt;
    ls    = hist[$-1];
    m_k++;
    dwell = m_k - m_entry;
    nxt   = m_phase;
    if (sw) begin
      nxt     = M_RESET;
      m_retry = 0;
    end else begin
      case (m_phase)
        M_RESET:  if (dwell == RST_CYCLES) nxt = M_WAIT;
        M_WAIT: begin
          if (ls) nxt = M_STABLE;
          else if (dwell == LOCK_TIMEOUT) begin
            if (m_retry == MAX_RETRY) nxt = M_FAIL;
            else begin
              nxt = M_RESET;
              m_retry++;
            end
          end
        end
        M_STABLE: begin
          if (!ls) nxt = M_WAIT;
          else if (dwell == LOCK_STABLE) begin
            nxt     = M_RUN;
            m_retry = 0;
          end
        end
        M_RUN:    if (!ls) nxt = M_RESET;
        default:  nxt = m_phase;
      endcase
    end
    if (sw || nxt != m_phase) m_entry = m_k;
    m_phase = nxt;
    hist.push_back(lk);
    if (hist.size() > 4) void'(hist.pop_front());
  endtask

  task automatic check_outputs(input string ctx);
    check_bit({ctx, ".pll_rst"},    pll_rst,    (m_phase == M_RESET) || (m_phase == M_FAIL));
    check_bit({ctx, ".user_rst_n"}, user_rst_n, m_phase == M_RUN);
    check_bit({ctx, ".ready"},      ready,      m_phase == M_RUN);
    check_bit({ctx, ".fail"},       fail,       m_phase == M_FAIL);
    check_int({ctx, ".retry_cnt"},  32'(retry_cnt), m_retry);
  endtask

  // One clock: drive inputs, advance the model on the edge, compare 1 ns later.
  task automatic step(input logic lk, input logic sw, input string ctx);
    pll_lock   = lk;
    sw_rst_req = sw;
    @(posedge sys_clk);
    model_edge(lk, sw);
    #1;
    check_outputs(ctx);
  endtask

  initial begin
    int   first_ready;
    int   drop_lat;
    int   run_left;
    logic rl;

    // Power-on reset
    sys_rst_n  = 1'b0;
    pll_lock   = 1'b0;
    sw_rst_req = 1'b0;
    model_reset();
    #12;
    check_outputs("por");
    #10;
    sys_rst_n = 1'b1;

    // Nominal bring-up: lock from cycle 6, ready expected on edge 6+2+LOCK_STABLE
    first_ready = 0;
    for (int c = 1; c <= 40; c++) begin
      step(c >= 6, 1'b0, "nominal");
      if (first_ready == 0 && ready) first_ready = c;
    end
    check_int("nominal_ready_edge", first_ready, 6 + 2 + LOCK_STABLE);

    // Lock drop in RUN: user reset must fall within 3 cycles, then relock
    drop_lat = 0;
    for (int i = 1; i <= 6; i++) begin
      step(1'b0, 1'b0, "run_drop");
      if (drop_lat == 0 && !user_rst_n) drop_lat = i;
    end
    check_bit("run_drop_within_3", (drop_lat >= 1) && (drop_lat <= 3), 1'b1);
    for (int i = 0; i < 40; i++) step(1'b1, 1'b0, "relock");

    // One-cycle lock glitch in STABLE
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, "pre_glitch");
    for (int i = 0; i < 100 && !(m_phase == M_STABLE && m_k - m_entry == 3); i++)
      step(1'b1, 1'b0, "to_stable");
    step(1'b0, 1'b0, "glitch");
    for (int i = 0; i < 30; i++) step(1'b1, 1'b0, "post_glitch");

    // Lock never returns: retries exhaust into FAIL
    for (int i = 0; i < 90; i++) step(1'b0, 1'b0, "no_lock");
    step(1'b0, 1'b1, "sw_in_fail");
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, "after_sw_fail");

    // Request coincident with a WAIT_LOCK timeout after one recorded retry
    for (int i = 0; i < 200 && !(m_phase == M_WAIT && m_retry == 1 &&
                                 (m_k + 1 - m_entry) == LOCK_TIMEOUT); i++)
      step(1'b0, 1'b0, "to_timeout");
    step(1'b0, 1'b1, "sw_at_timeout");
    for (int i = 0; i < 2; i++) step(1'b0, 1'b0, "after_sw_timeout");

    // Request while already in RESET restarts the hold
    step(1'b0, 1'b1, "sw_in_reset");
    for (int i = 0; i < 8; i++) step(1'b0, 1'b0, "reset_restart");

    // Asynchronous reset mid-STABLE, no clock edge needed
    for (int i = 0; i < 100 && !(m_phase == M_STABLE && m_k - m_entry == 3); i++)
      step(1'b1, 1'b0, "to_stable2");
    #2;
    sys_rst_n = 1'b0;
    model_reset();
    #1;
    check_outputs("async_rst");
    @(posedge sys_clk);
    #1;
    check_outputs("async_rst_hold");
    #3;
    sys_rst_n = 1'b1;
    for (int i = 0; i < 30; i++) step(1'b1, 1'b0, "after_async");

    // Randomized lock runs with occasional software requests
    run_left = 0;
    rl       = 1'b0;
    for (int i = 0; i < 600; i++) begin
      if (run_left == 0) begin
        rl       = ($urandom_range(0, 3) != 0);
        run_left = $urandom_range(1, 40);
      end
      run_left--;
      step(rl, $urandom_range(0, 99) == 0, "random");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/pll_rst_ctrl.md
PLL_RST_CTRL -- requirements
Module: pll_rst_ctrl

Interface
REQ-001 SHALL have parameter RST_CYCLES, default 100, PLL reset hold length in sys_clk cycles (>=1).
REQ-002 SHALL have parameter LOCK_TIMEOUT, default 50000, maximum wait for lock per attempt in cycles (>=1).
REQ-003 SHALL have parameter LOCK_STABLE, default 1024, number of consecutive locked cycles required before release (>=1).
REQ-004 SHALL have parameter MAX_RETRY, default 7, retries allowed before declaring failure (0..7).
REQ-005 sys_clk  input  1  single clock for all logic; PLL reference clock domain.
REQ-006 sys_rst_n  input  1  reset; asynchronous assert, active-low.
REQ-007 pll_lock  input  1  PLL lock indicator; asynchronous to sys_clk.
REQ-008 sw_rst_req  input  1  single-cycle software request to restart the PLL sequence.
REQ-009 pll_rst  output  1  active-high reset to the PLL RST pin.
REQ-010 user_rst_n  output  1  active-low reset for logic clocked by the PLL outputs.
REQ-011 ready  output  1  high while the PLL is locked and released.
REQ-012 fail  output  1  high when retries are exhausted.
REQ-013 retry_cnt  output  3  number of timeouts in the current bring-up sequence.

Function
REQ-014 pll_lock SHALL pass through a 2-flop synchronizer; lock_s lags pll_lock by 2 cycles; no other logic samples pll_lock.
REQ-015 The FSM SHALL have states RESET, WAIT_LOCK, STABLE, RUN, FAIL; all outputs are registered and decode from state only, changing on the same edge as the state.
REQ-016 Single shared cycle counter, width clog2(max(RST_CYCLES,LOCK_TIMEOUT,LOCK_STABLE))+1; cleared on every state change.
REQ-017 RESET: pll_rst=1; at counter==RST_CYCLES-1 go to WAIT_LOCK; pll_rst is high exactly RST_CYCLES cycles per entry.
REQ-018 WAIT_LOCK: pll_rst=0; lock_s=1 -> STABLE; otherwise at counter==LOCK_TIMEOUT-1: if retry_cnt==MAX_RETRY -> FAIL, else retry_cnt+1 -> RESET.
REQ-019 STABLE: lock_s=0 -> WAIT_LOCK (no retry increment, timeout restarts); lock_s=1 at counter==LOCK_STABLE-1 -> RUN.
REQ-020 RUN: user_rst_n=1, ready=1, retry_cnt cleared on entry; lock_s=0 -> RESET with retry_cnt unchanged (0).
REQ-021 FAIL: pll_rst=1, fail=1, user_rst_n=0; terminal until sw_rst_req or sys_rst_n.
REQ-022 user_rst_n=1 and ready=1 only in RUN; both drop on the edge that leaves RUN.
REQ-023 sw_rst_req=1 in any state SHALL force RESET next edge, clearing counter, retry_cnt and fail; it has priority over every other transition, including timeout and lock events in the same cycle.
REQ-024 sw_rst_req asserted while already in RESET SHALL restart the RST_CYCLES hold from zero.
REQ-025 retry_cnt SHALL never exceed MAX_RETRY; with MAX_RETRY=0 the first timeout goes directly to FAIL.

Reset
REQ-026 sys_rst_n low SHALL asynchronously force state=RESET, counter=0, retry_cnt=0, synchronizer flops=0, pll_rst=1, user_rst_n=0, ready=0, fail=0.
REQ-027 Release of sys_rst_n SHALL be synchronous; the first count occurs on the first rising edge after release.
REQ-028 sys_rst_n asserted mid-operation (any state) SHALL take effect immediately without waiting for a clock edge.

Verification (RST_CYCLES=4, LOCK_TIMEOUT=16, LOCK_STABLE=8, MAX_RETRY=2)
REQ-029 Nominal: release reset, pll_lock=1 from cycle 6 -> pll_rst high cycles 1-4; user_rst_n and ready rise exactly 2+8 cycles after lock enters WAIT_LOCK path; retry_cnt=0.
REQ-030 Lock never asserts -> three pll_rst pulses of 4 cycles separated by 16-cycle waits; retry_cnt steps 1,2; fail=1 and pll_rst=1 held after third timeout.
REQ-031 Lock glitch low for 1 cycle during STABLE -> return to WAIT_LOCK; ready delayed by full 8-cycle restart; retry_cnt unchanged.
REQ-032 Lock drop in RUN -> user_rst_n=0 and ready=0 within 3 cycles of pll_lock falling; pll_rst pulses 4 cycles; relock releases again.
REQ-033 sw_rst_req in FAIL, and sw_rst_req coincident with WAIT_LOCK timeout -> RESET next edge, fail=0, retry_cnt=0, no increment recorded.
REQ-034 sys_rst_n pulsed low mid-STABLE with no clock edge -> all outputs at reset values immediately.
